// File: rtl/fpdivsqrt_req_arbiter.sv
// Round-robin front end sharing one non-pipelined fp div/sqrt unit between NUM_REQ requesters.
// One operation in flight; the result is held until its owner accepts it or the owner flushes.
module fpdivsqrt_req_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [2*NUM_REQ-1:0]  req_fp_format_i,
    input  logic [NUM_REQ-1:0]    req_is_fdiv_i,
    input  logic [64*NUM_REQ-1:0] req_opa_i,
    input  logic [64*NUM_REQ-1:0] req_opb_i,
    input  logic [3*NUM_REQ-1:0]  req_rm_i,
    input  logic [NUM_REQ-1:0]    req_flush_i,
    output logic [NUM_REQ-1:0]    rsp_valid_o,
    input  logic [NUM_REQ-1:0]    rsp_ready_i,
    output logic [63:0]           rsp_res_o,
    output logic [4:0]            rsp_fflags_o,
    output logic                  div_start_valid_o,
    input  logic                  div_start_ready_i,
    output logic                  div_flush_o,
    output logic [1:0]            div_fp_format_o,
    output logic                  div_is_fdiv_o,
    output logic [63:0]           div_opa_o,
    output logic [63:0]           div_opb_o,
    output logic [2:0]            div_rm_o,
    input  logic                  div_finish_valid_i,
    output logic                  div_finish_ready_o,
    input  logic [63:0]           div_res_i,
    input  logic [4:0]            div_fflags_i,
    output logic                  busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] rr_q, rr_d;
    logic [ID_W-1:0] owner_q, owner_d;
    logic [1:0]      fmt_q, fmt_d;
    logic            fdiv_q, fdiv_d;
    logic [63:0]     opa_q, opa_d;
    logic [63:0]     opb_q, opb_d;
    logic [2:0]      rm_q, rm_d;
    logic [63:0]     res_q, res_d;
    logic [4:0]      ff_q, ff_d;

    logic [NUM_REQ-1:0] eligible;
    logic               gfound;
    logic [ID_W-1:0]    gidx;
    logic [ID_W-1:0]    cand;
    logic [ID_W-1:0]    next_owner;
    logic               owner_flush;

    logic [1:0]  fmt_a  [NUM_REQ];
    logic [63:0] opa_a  [NUM_REQ];
    logic [63:0] opb_a  [NUM_REQ];
    logic [2:0]  rm_a   [NUM_REQ];

    function automatic logic [ID_W-1:0] wrap_idx(input int unsigned v);
        return ID_W'((v >= NUM_REQ) ? (v - NUM_REQ) : v);
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            fmt_a[i] = req_fp_format_i[2*i +: 2];
            opa_a[i] = req_opa_i[64*i +: 64];
            opb_a[i] = req_opb_i[64*i +: 64];
            rm_a[i]  = req_rm_i[3*i +: 3];
        end
    end

    // Scan starting at rr_q so the requester after the last owner wins ties.
    always_comb begin
        eligible = req_valid_i & ~req_flush_i;
        gfound   = 1'b0;
        gidx     = '0;
        cand     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = wrap_idx(32'(rr_q) + i);
            if (!gfound && eligible[cand]) begin
                gfound = 1'b1;
                gidx   = cand;
            end
        end
    end

    assign next_owner  = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign owner_flush = req_flush_i[owner_q];

    always_comb begin
        state_d            = state_q;
        rr_d               = rr_q;
        owner_d            = owner_q;
        fmt_d              = fmt_q;
        fdiv_d             = fdiv_q;
        opa_d              = opa_q;
        opb_d              = opb_q;
        rm_d               = rm_q;
        res_d              = res_q;
        ff_d               = ff_q;
        req_ready_o        = '0;
        rsp_valid_o        = '0;
        div_start_valid_o  = 1'b0;
        div_finish_ready_o = 1'b0;
        div_flush_o        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (gfound) begin
                    req_ready_o[gidx] = 1'b1;
                    owner_d           = gidx;
                    fmt_d             = fmt_a[gidx];
                    fdiv_d            = req_is_fdiv_i[gidx];
                    opa_d             = opa_a[gidx];
                    opb_d             = opb_a[gidx];
                    rm_d              = rm_a[gidx];
                    state_d           = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (owner_flush) begin
                    div_flush_o = 1'b1;
                    rr_d        = next_owner;
                    state_d     = S_IDLE;
                end else begin
                    div_start_valid_o = 1'b1;
                    if (div_start_ready_i) state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A flush takes priority over a same-cycle finish; the divider discards its result.
                if (owner_flush) begin
                    div_flush_o = 1'b1;
                    rr_d        = next_owner;
                    state_d     = S_IDLE;
                end else begin
                    div_finish_ready_o = 1'b1;
                    if (div_finish_valid_i) begin
                        res_d   = div_res_i;
                        ff_d    = div_fflags_i;
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (owner_flush) begin
                    rr_d    = next_owner;
                    state_d = S_IDLE;
                end else begin
                    rsp_valid_o[owner_q] = 1'b1;
                    if (rsp_ready_i[owner_q]) begin
                        rr_d    = next_owner;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (rst) begin
            req_ready_o = '0;
            div_flush_o = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            fmt_q   <= '0;
            fdiv_q  <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            rm_q    <= '0;
            res_q   <= '0;
            ff_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            fmt_q   <= fmt_d;
            fdiv_q  <= fdiv_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            rm_q    <= rm_d;
            res_q   <= res_d;
            ff_q    <= ff_d;
        end
    end

    assign div_fp_format_o = fmt_q;
    assign div_is_fdiv_o   = fdiv_q;
    assign div_opa_o       = opa_q;
    assign div_opb_o       = opb_q;
    assign div_rm_o        = rm_q;
    assign rsp_res_o       = res_q;
    assign rsp_fflags_o    = ff_q;
    assign busy_o          = (state_q != S_IDLE);

endmodule

// File: tb/tb_fpdivsqrt_req_arbiter.sv
// Bench for fpdivsqrt_req_arbiter: transaction-level model plus a behavioural divider stub,
// directed scenarios with literal expectations, then a random soak over four requesters.
module tb_fpdivsqrt_req_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0, req_ready_o, req_isdiv = '0, req_flush = '0;
    logic [2*N-1:0] req_fmt = '0;
    logic [64*N-1:0] req_opa = '0, req_opb = '0;
    logic [3*N-1:0] req_rm = '0;
    logic [N-1:0]   rsp_valid_o, rsp_ready = '0;
    logic [63:0]    rsp_res_o;
    logic [4:0]     rsp_fflags_o;
    logic           div_start_valid_o, div_start_ready_i = 1'b0, div_flush_o;
    logic [1:0]     div_fp_format_o;
    logic           div_is_fdiv_o;
    logic [63:0]    div_opa_o, div_opb_o;
    logic [2:0]     div_rm_o;
    logic           div_finish_valid_i = 1'b0, div_finish_ready_o;
    logic [63:0]    div_res_i = '0;
    logic [4:0]     div_fflags_i = '0;
    logic           busy_o;

    fpdivsqrt_req_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .req_fp_format_i(req_fmt), .req_is_fdiv_i(req_isdiv),
        .req_opa_i(req_opa), .req_opb_i(req_opb), .req_rm_i(req_rm),
        .req_flush_i(req_flush),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
        .rsp_res_o(rsp_res_o), .rsp_fflags_o(rsp_fflags_o),
        .div_start_valid_o(div_start_valid_o), .div_start_ready_i(div_start_ready_i),
        .div_flush_o(div_flush_o),
        .div_fp_format_o(div_fp_format_o), .div_is_fdiv_o(div_is_fdiv_o),
        .div_opa_o(div_opa_o), .div_opb_o(div_opb_o), .div_rm_o(div_rm_o),
        .div_finish_valid_i(div_finish_valid_i), .div_finish_ready_o(div_finish_ready_o),
        .div_res_i(div_res_i), .div_fflags_i(div_fflags_i),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int lat = 2;
    bit start_block = 1'b0, rnd_mode = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Divider behaviour: F64 divide is real IEEE division, everything else a fixed mixing function.
    function automatic logic [63:0] f_res(input logic [1:0] f, input logic d, input logic [63:0] a,
                                          input logic [63:0] b, input logic [2:0] r);
        if (d && f == 2'd2) return $realtobits($bitstoreal(a) / $bitstoreal(b));
        return a ^ {b[31:0], b[63:32]} ^ {59'd0, r, f};
    endfunction

    function automatic logic [4:0] f_ff(input logic [1:0] f, input logic d, input logic [2:0] r);
        return (d && f == 2'd2) ? 5'd0 : {r, f};
    endfunction

    // Divider stub: state advances at the negedge, outputs driven just after the posedge.
    bit s_busy = 0, s_done = 0;
    int s_cnt = 0;
    logic [63:0] s_res = '0;
    logic [4:0]  s_ff = '0;

    always @(negedge clk) begin
        if (rst) begin
            s_busy = 0; s_done = 0; s_cnt = 0;
        end else if (div_flush_o) begin
            s_busy = 0; s_done = 0;
        end else if (!s_busy) begin
            if (div_start_valid_o && div_start_ready_i) begin
                s_busy = 1; s_done = 0;
                s_cnt  = rnd_mode ? int'($urandom_range(0, 5)) : lat;
                s_res  = f_res(div_fp_format_o, div_is_fdiv_o, div_opa_o, div_opb_o, div_rm_o);
                s_ff   = f_ff(div_fp_format_o, div_is_fdiv_o, div_rm_o);
            end
        end else if (!s_done) begin
            if (s_cnt == 0) s_done = 1; else s_cnt--;
        end else if (div_finish_valid_i && div_finish_ready_o) begin
            s_busy = 0; s_done = 0;
        end
    end

    always @(posedge clk) begin
        #2;
        div_start_ready_i  = !s_busy && !start_block && (!rnd_mode || ($urandom_range(0, 3) != 0));
        div_finish_valid_i = s_done;
        div_res_i          = s_done ? s_res : 64'hDEAD_BEEF_DEAD_BEEF;
        div_fflags_i       = s_done ? s_ff : 5'h1F;
    end

    // Transaction model: one op per grant, round-robin pointer moves past the owner on completion/kill.
    bit          m_busy = 0, m_started = 0, m_done = 0;
    int          m_ptr = 0, m_owner = 0;
    logic [1:0]  m_fmt;
    logic        m_dv;
    logic [63:0] m_a, m_b;
    logic [2:0]  m_rm;
    int          m_rsp = 0, m_grant = 0, dut_rsp = 0, dut_acc = 0;

    always @(negedge clk) begin
        int   g;
        bit   gf, oflush, e_sv, e_fl, e_fr;
        logic [N-1:0] e_ready, e_rv;
        if (rst) begin
            m_busy = 0; m_started = 0; m_done = 0; m_ptr = 0; m_owner = 0;
        end else begin
            gf = 0; g = 0;
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_ptr + i) % N;
                if (!gf && req_valid[k] && !req_flush[k]) begin gf = 1; g = k; end
            end
            oflush  = m_busy && req_flush[m_owner];
            e_ready = (!m_busy && gf) ? N'(1 << g) : '0;
            e_sv    = m_busy && !m_started && !oflush;
            e_fl    = m_busy && !m_done && oflush;
            e_fr    = m_busy && m_started && !m_done && !oflush;
            e_rv    = (m_busy && m_done && !oflush) ? N'(1 << m_owner) : '0;

            chk("m_req_ready", 64'(req_ready_o), 64'(e_ready));
            chk("m_start_valid", 64'(div_start_valid_o), 64'(e_sv));
            chk("m_div_flush", 64'(div_flush_o), 64'(e_fl));
            chk("m_finish_ready", 64'(div_finish_ready_o), 64'(e_fr));
            chk("m_rsp_valid", 64'(rsp_valid_o), 64'(e_rv));
            chk("m_busy", 64'(busy_o), 64'(m_busy));
            if (e_sv) begin
                chk("m_div_opa", div_opa_o, m_a);
                chk("m_div_opb", div_opb_o, m_b);
                chk("m_div_ctl", 64'({div_fp_format_o, div_is_fdiv_o, div_rm_o}), 64'({m_fmt, m_dv, m_rm}));
            end
            if (e_rv != '0) begin
                chk("m_rsp_res", rsp_res_o, f_res(m_fmt, m_dv, m_a, m_b, m_rm));
                chk("m_rsp_ff", 64'(rsp_fflags_o), 64'(f_ff(m_fmt, m_dv, m_rm)));
            end

            if ((rsp_valid_o & rsp_ready) != '0) dut_rsp++;
            if ((req_ready_o & req_valid) != '0) dut_acc++;

            if (oflush) begin
                m_busy = 0; m_ptr = (m_owner + 1) % N;
            end else if (!m_busy) begin
                if (gf) begin
                    m_busy = 1; m_started = 0; m_done = 0; m_owner = g; m_grant++;
                    m_fmt = req_fmt[2*g +: 2]; m_dv = req_isdiv[g];
                    m_a = req_opa[64*g +: 64]; m_b = req_opb[64*g +: 64]; m_rm = req_rm[3*g +: 3];
                end
            end else if (!m_started) begin
                if (div_start_ready_i) m_started = 1;
            end else if (!m_done) begin
                if (div_finish_valid_i) m_done = 1;
            end else if (rsp_ready[m_owner]) begin
                m_busy = 0; m_ptr = (m_owner + 1) % N; m_rsp++;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input int k, input logic [1:0] f, input logic d, input logic [63:0] a,
                           input logic [63:0] b, input logic [2:0] r);
        req_fmt[2*k +: 2] = f; req_isdiv[k] = d;
        req_opa[64*k +: 64] = a; req_opb[64*k +: 64] = b; req_rm[3*k +: 3] = r;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1; req_valid = '0; req_flush = '0; rsp_ready = '0; start_block = 1'b0;
        step(); step();
        rst = 1'b0;
        @(negedge clk);
    endtask

    function automatic bit cond(input int kind);
        case (kind)
            0: return rsp_valid_o != '0;
            1: return div_finish_valid_i && div_finish_ready_o;
            2: return busy_o == 1'b0;
            3: return div_finish_ready_o;
            default: return req_ready_o != '0;
        endcase
    endfunction

    task automatic wait_for(input int kind, input string nm);
        int c = 0;
        while (!cond(kind) && c < 200) begin @(negedge clk); c++; end
        if (!cond(kind)) begin
            n_chk++; n_fail++;
            $display("FAIL %s: timeout, actual=0 required=1", nm);
        end
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_start_valid", 64'(div_start_valid_o), 64'd0);
        chk("rst_flush", 64'(div_flush_o), 64'd0);
        chk("rst_opa", div_opa_o, 64'd0);
        chk("rst_res", rsp_res_o, 64'd0);

        // T1: single F64 6.0/3.0
        step();
        set_req(0, 2'd2, 1'b1, 64'h4018_0000_0000_0000, 64'h4008_0000_0000_0000, 3'd0);
        req_valid = 4'b0001; rsp_ready = 4'b0001; lat = 3;
        @(negedge clk); chk("t1_ready", 64'(req_ready_o), 64'h1);
        step(); req_valid = '0;
        @(negedge clk);
        chk("t1_start", 64'(div_start_valid_o), 64'd1);
        chk("t1_opa", div_opa_o, 64'h4018_0000_0000_0000);
        wait_for(1, "t1_finish");
        @(negedge clk);
        chk("t1_rsp_valid", 64'(rsp_valid_o), 64'h1);
        chk("t1_res", rsp_res_o, 64'h4000_0000_0000_0000);
        chk("t1_ff", 64'(rsp_fflags_o), 64'd0);

        // T2: contention, alternating grants
        do_reset();
        step();
        set_req(0, 2'd1, 1'b0, 64'h0000_0000_4080_0000, 64'd0, 3'd1);
        set_req(1, 2'd0, 1'b1, 64'h0000_0000_0000_3C00, 64'h0000_0000_0000_4000, 3'd2);
        req_valid = 4'b0011; rsp_ready = 4'b0011; lat = 2;
        @(negedge clk);
        for (int n = 0; n < 4; n++) begin
            wait_for(4, "t2_grant");
            chk("t2_grant", 64'(req_ready_o), (n % 2 == 0) ? 64'h1 : 64'h2);
            wait_for(0, "t2_rsp");
            chk("t2_rsp_owner", 64'(rsp_valid_o), (n % 2 == 0) ? 64'h1 : 64'h2);
            chk("t2_res", rsp_res_o, (n % 2 == 0) ? 64'h0000_0000_4080_0005 : 64'h0000_4000_0000_3C08);
            chk("t2_ff", 64'(rsp_fflags_o), (n % 2 == 0) ? 64'h05 : 64'h08);
            @(negedge clk);
        end
        step(); req_valid = '0;
        @(negedge clk); wait_for(2, "t2_idle");

        // T3: owner 1 backpressures its response
        do_reset();
        step();
        set_req(1, 2'd2, 1'b1, 64'h3FF0_0000_0000_0000, 64'h4010_0000_0000_0000, 3'd0);
        set_req(0, 2'd1, 1'b0, 64'h1234, 64'd0, 3'd0);
        req_valid = 4'b0010; rsp_ready = 4'b0001; lat = 1;
        @(negedge clk); wait_for(0, "t3_rsp");
        step(); req_valid = 4'b0011;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("t3_rsp_held", 64'(rsp_valid_o), 64'h2);
            chk("t3_res_stable", rsp_res_o, 64'h3FD0_0000_0000_0000);
            chk("t3_no_grant", 64'(req_ready_o), 64'd0);
            chk("t3_busy", 64'(busy_o), 64'd1);
            step();
        end
        rsp_ready = 4'b0011;
        @(negedge clk); @(negedge clk);
        chk("t3_next_grant", 64'(req_ready_o), 64'h1);
        step(); req_valid = '0;
        @(negedge clk); wait_for(2, "t3_idle");

        // T4: flush while waiting for the divider
        do_reset();
        step();
        set_req(0, 2'd2, 1'b1, 64'h4018_0000_0000_0000, 64'h4008_0000_0000_0000, 3'd0);
        req_valid = 4'b0001; rsp_ready = 4'b0011; lat = 8;
        @(negedge clk); chk("t4_ready", 64'(req_ready_o), 64'h1);
        step(); req_valid = '0;
        @(negedge clk); wait_for(3, "t4_wait");
        step(); req_flush = 4'b0001;
        @(negedge clk);
        chk("t4_div_flush", 64'(div_flush_o), 64'd1);
        step(); req_flush = '0;
        @(negedge clk);
        chk("t4_idle", 64'(busy_o), 64'd0);
        chk("t4_flush_drop", 64'(div_flush_o), 64'd0);
        for (int c = 0; c < 12; c++) begin
            chk("t4_no_rsp", 64'(rsp_valid_o), 64'd0);
            @(negedge clk);
        end
        step();
        set_req(1, 2'd2, 1'b1, 64'h4022_0000_0000_0000, 64'h4008_0000_0000_0000, 3'd0);
        req_valid = 4'b0010;
        @(negedge clk); chk("t4_ready1", 64'(req_ready_o), 64'h2);
        step(); req_valid = '0;
        @(negedge clk); wait_for(0, "t4_rsp");
        chk("t4_rsp_owner", 64'(rsp_valid_o), 64'h2);
        chk("t4_res", rsp_res_o, 64'h4008_0000_0000_0000);
        chk("t4_ff", 64'(rsp_fflags_o), 64'd0);

        // T5: divider refuses start for 5 cycles
        do_reset();
        step();
        start_block = 1'b1;
        set_req(0, 2'd0, 1'b0, 64'h3C00, 64'd0, 3'd3);
        req_valid = 4'b0001; rsp_ready = 4'b0001; lat = 2;
        @(negedge clk); chk("t5_ready", 64'(req_ready_o), 64'h1);
        step(); req_valid = '0;
        set_req(0, 2'd3, 1'b1, 64'hFFFF, 64'h1, 3'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t5_start_held", 64'(div_start_valid_o), 64'd1);
            chk("t5_opa", div_opa_o, 64'h3C00);
            chk("t5_ctl", 64'({div_fp_format_o, div_is_fdiv_o, div_rm_o}), 64'h03);
            step();
        end
        start_block = 1'b0;
        @(negedge clk); wait_for(0, "t5_rsp");
        chk("t5_res", rsp_res_o, 64'h3C0C);
        chk("t5_ff", 64'(rsp_fflags_o), 64'h0C);

        // reset during an in-flight op
        do_reset();
        step();
        set_req(1, 2'd1, 1'b0, 64'h5555, 64'd0, 3'd4);
        req_valid = 4'b0010; rsp_ready = 4'b0011; lat = 6;
        @(negedge clk);
        step(); req_valid = '0;
        @(negedge clk); wait_for(3, "t6_wait");
        step(); rst = 1'b1;
        @(negedge clk); chk("t6_no_flush", 64'(div_flush_o), 64'd0);
        step(); rst = 1'b0;
        @(negedge clk);
        chk("t6_busy", 64'(busy_o), 64'd0);
        chk("t6_rsp", 64'(rsp_valid_o), 64'd0);
        chk("t6_opa", div_opa_o, 64'd0);
        step(); req_valid = 4'b0011;
        @(negedge clk); chk("t6_ptr_reset", 64'(req_ready_o), 64'h1);
        step(); req_valid = '0;
        @(negedge clk); wait_for(2, "t6_idle");

        // random soak, 4 requesters
        do_reset();
        rnd_mode = 1'b1;
        for (int c = 0; c < 40000 && m_rsp < 1500; c++) begin
            step();
            req_valid = N'($urandom);
            rsp_ready = N'($urandom);
            for (int k = 0; k < N; k++) begin
                req_flush[k] = ($urandom_range(0, 23) == 0);
                set_req(k, 2'($urandom_range(0, 3)), 1'($urandom), {$urandom, $urandom},
                        {$urandom, $urandom}, 3'($urandom_range(0, 7)));
            end
        end
        step();
        rnd_mode = 1'b0; req_valid = '0; req_flush = '0; rsp_ready = '1;
        @(negedge clk); wait_for(2, "rnd_drain");
        chk("rnd_progress", 64'(m_rsp >= 1500), 64'd1);
        chk("rnd_rsp_count", 64'(dut_rsp), 64'(m_rsp));
        chk("rnd_accept_count", 64'(dut_acc), 64'(m_grant));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
